// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU (0) and load (1) write-back,
// with one registered write stage and read-port forwarding of the in-flight write.
module regfile_wb_arbiter #(
  parameter int RegisterSize = 5,
  parameter int OperandSize  = 32,
  parameter int CountWidth   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_valid_0,
  input  logic [RegisterSize-1:0] wb_addr_0,
  input  logic [OperandSize-1:0]  wb_data_0,
  output logic                    wb_ready_0,
  input  logic                    wb_valid_1,
  input  logic [RegisterSize-1:0] wb_addr_1,
  input  logic [OperandSize-1:0]  wb_data_1,
  output logic                    wb_ready_1,
  output logic                    write_enable_3,
  output logic [RegisterSize-1:0] addr_3,
  output logic [OperandSize-1:0]  write_data_3,
  input  logic [RegisterSize-1:0] rd_addr_1,
  input  logic [RegisterSize-1:0] rd_addr_2,
  input  logic [OperandSize-1:0]  rf_read_data_1,
  input  logic [OperandSize-1:0]  rf_read_data_2,
  output logic [OperandSize-1:0]  read_data_1,
  output logic [OperandSize-1:0]  read_data_2,
  output logic [CountWidth-1:0]   grant_count_0,
  output logic [CountWidth-1:0]   grant_count_1,
  output logic                    busy
);

  logic                    rr_q, rr_d;
  logic                    we_q, we_d;
  logic [RegisterSize-1:0] addr_q, addr_d;
  logic [OperandSize-1:0]  data_q, data_d;
  logic [CountWidth-1:0]   cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic                    xfer;

  assign wb_ready_0 = ~rst & wb_valid_0 & (~wb_valid_1 | ~rr_q);
  assign wb_ready_1 = ~rst & wb_valid_1 & (~wb_valid_0 |  rr_q);
  assign xfer       = wb_ready_0 | wb_ready_1;

  always_comb begin
    rr_d   = rr_q;
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (xfer) begin
      // Pointer moves to whichever requester lost (or was idle) this time.
      rr_d   = wb_ready_0;
      addr_d = wb_ready_1 ? wb_addr_1 : wb_addr_0;
      data_d = wb_ready_1 ? wb_data_1 : wb_data_0;
      we_d   = (addr_d != '0);
    end
    if (wb_ready_0 && cnt0_q != '1) cnt0_d = cnt0_q + 1'b1;
    if (wb_ready_1 && cnt1_q != '1) cnt1_d = cnt1_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q   <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      rr_q   <= rr_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  // A write already registered when reset arrives must not reach the register file.
  assign write_enable_3 = we_q & ~rst;
  assign addr_3         = addr_q;
  assign write_data_3   = data_q;
  assign busy           = write_enable_3;
  assign grant_count_0  = cnt0_q;
  assign grant_count_1  = cnt1_q;

  assign read_data_1 = (write_enable_3 && addr_q == rd_addr_1 && rd_addr_1 != '0) ? data_q : rf_read_data_1;
  assign read_data_2 = (write_enable_3 && addr_q == rd_addr_2 && rd_addr_2 != '0) ? data_q : rf_read_data_2;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; counters narrowed to 4 bits so saturation is reachable.
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid_0, wb_valid_1, wb_ready_0, wb_ready_1;
  logic [4:0]  wb_addr_0, wb_addr_1, addr_3, rd_addr_1, rd_addr_2;
  logic [31:0] wb_data_0, wb_data_1, write_data_3;
  logic [31:0] rf_read_data_1, rf_read_data_2, read_data_1, read_data_2;
  logic        write_enable_3, busy;
  logic [3:0]  grant_count_0, grant_count_1;
  int          vecs = 0;
  int          errs = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.RegisterSize(5), .OperandSize(32), .CountWidth(4)) dut (
    .clk(clk), .rst(rst),
    .wb_valid_0(wb_valid_0), .wb_addr_0(wb_addr_0), .wb_data_0(wb_data_0), .wb_ready_0(wb_ready_0),
    .wb_valid_1(wb_valid_1), .wb_addr_1(wb_addr_1), .wb_data_1(wb_data_1), .wb_ready_1(wb_ready_1),
    .write_enable_3(write_enable_3), .addr_3(addr_3), .write_data_3(write_data_3),
    .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
    .rf_read_data_1(rf_read_data_1), .rf_read_data_2(rf_read_data_2),
    .read_data_1(read_data_1), .read_data_2(read_data_2),
    .grant_count_0(grant_count_0), .grant_count_1(grant_count_1), .busy(busy)
  );

  task automatic idle_inputs();
    wb_valid_0 = 0; wb_valid_1 = 0; wb_addr_0 = 0; wb_addr_1 = 0;
    wb_data_0 = 0; wb_data_1 = 0; rd_addr_1 = 0; rd_addr_2 = 0;
    rf_read_data_1 = 0; rf_read_data_2 = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); idle_inputs(); rst = 1;
    @(posedge clk); @(negedge clk); rst = 0;
  endtask

  task automatic test_reset();
    @(negedge clk); idle_inputs(); rst = 1; wb_valid_0 = 1; wb_valid_1 = 1;
    #1;
    vecs++; if ({wb_ready_0, wb_ready_1} !== 2'b00) begin errs++; $display("FAIL rst_ready got %b want 00", {wb_ready_0, wb_ready_1}); end
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk); idle_inputs(); rst = 0; #1;
    vecs++; if (write_enable_3 !== 1'b0) begin errs++; $display("FAIL rst_we got %b want 0", write_enable_3); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy got %b want 0", busy); end
    vecs++; if ({wb_ready_0, wb_ready_1} !== 2'b00) begin errs++; $display("FAIL idle_ready got %b want 00", {wb_ready_0, wb_ready_1}); end
    vecs++; if ({grant_count_0, grant_count_1} !== 8'h00) begin errs++; $display("FAIL rst_counts got %h want 00", {grant_count_0, grant_count_1}); end
    vecs++; if ({addr_3, write_data_3} !== 37'h0) begin errs++; $display("FAIL rst_wport got %h/%h want 0/0", addr_3, write_data_3); end
  endtask

  task automatic test_single();
    do_reset();
    wb_valid_0 = 1; wb_addr_0 = 5; wb_data_0 = 32'hDEADBEEF; #1;
    vecs++; if ({wb_ready_0, wb_ready_1} !== 2'b10) begin errs++; $display("FAIL single_ready got %b want 10", {wb_ready_0, wb_ready_1}); end
    @(posedge clk); #1;
    vecs++; if ({write_enable_3, busy, addr_3} !== {2'b11, 5'd5}) begin errs++; $display("FAIL single_we got %b%b a=%0d want 11 a=5", write_enable_3, busy, addr_3); end
    vecs++; if (write_data_3 !== 32'hDEADBEEF) begin errs++; $display("FAIL single_data got %h want deadbeef", write_data_3); end
    vecs++; if (grant_count_0 !== 4'd1) begin errs++; $display("FAIL single_cnt got %0d want 1", grant_count_0); end
    @(negedge clk); wb_valid_0 = 0;
    @(posedge clk); #1;
    vecs++; if ({write_enable_3, addr_3} !== {1'b0, 5'd5} || write_data_3 !== 32'hDEADBEEF) begin errs++; $display("FAIL single_hold got we=%b a=%0d d=%h want 0/5/deadbeef", write_enable_3, addr_3, write_data_3); end
  endtask

  task automatic test_contention();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wb_valid_0 = 1; wb_addr_0 = 3; wb_data_0 = 32'h100 + i;
      wb_valid_1 = 1; wb_addr_1 = 4; wb_data_1 = 32'h200 + i;
      #1;
      vecs++; if ({wb_ready_0, wb_ready_1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin errs++; $display("FAIL cont_ready[%0d] got %b", i, {wb_ready_0, wb_ready_1}); end
      @(posedge clk); #1;
      vecs++; if (write_enable_3 !== 1'b1 || addr_3 !== ((i % 2 == 0) ? 5'd3 : 5'd4)) begin errs++; $display("FAIL cont_wr[%0d] got we=%b a=%0d", i, write_enable_3, addr_3); end
      vecs++; if (write_data_3 !== ((i % 2 == 0) ? 32'h100 + i : 32'h200 + i)) begin errs++; $display("FAIL cont_data[%0d] got %h", i, write_data_3); end
      @(negedge clk);
    end
    idle_inputs();
    vecs++; if (grant_count_0 !== 4'd2 || grant_count_1 !== 4'd2) begin errs++; $display("FAIL cont_cnt got %0d/%0d want 2/2", grant_count_0, grant_count_1); end
  endtask

  task automatic test_same_addr_fwd();
    do_reset();
    wb_valid_0 = 1; wb_addr_0 = 7; wb_data_0 = 32'h11;
    wb_valid_1 = 1; wb_addr_1 = 7; wb_data_1 = 32'h22;
    rd_addr_1 = 7; rf_read_data_1 = 0; rd_addr_2 = 6; rf_read_data_2 = 32'hABCD;
    #1;
    vecs++; if (read_data_1 !== 32'h0) begin errs++; $display("FAIL fwd_pre got %h want 0", read_data_1); end
    @(posedge clk); #1;
    vecs++; if (read_data_1 !== 32'h11) begin errs++; $display("FAIL fwd_first got %h want 11", read_data_1); end
    vecs++; if (read_data_2 !== 32'hABCD) begin errs++; $display("FAIL fwd_pass2 got %h want abcd", read_data_2); end
    @(negedge clk); wb_valid_0 = 0; #1;
    vecs++; if (wb_ready_1 !== 1'b1) begin errs++; $display("FAIL fwd_loser_ready got %b want 1", wb_ready_1); end
    @(posedge clk); #1;
    vecs++; if (read_data_1 !== 32'h22 || addr_3 !== 5'd7) begin errs++; $display("FAIL fwd_second got %h a=%0d want 22 a=7", read_data_1, addr_3); end
    @(negedge clk); wb_valid_1 = 0; rf_read_data_1 = 32'h22;
    @(posedge clk); #1;
    vecs++; if (write_enable_3 !== 1'b0 || read_data_1 !== 32'h22) begin errs++; $display("FAIL fwd_after got we=%b d=%h want 0/22", write_enable_3, read_data_1); end
  endtask

  task automatic test_x0();
    do_reset();
    wb_valid_1 = 1; wb_addr_1 = 0; wb_data_1 = 32'hFFFF;
    rd_addr_1 = 0; rf_read_data_1 = 32'h55; #1;
    vecs++; if (wb_ready_1 !== 1'b1) begin errs++; $display("FAIL x0_ready got %b want 1", wb_ready_1); end
    @(posedge clk); #1;
    vecs++; if (write_enable_3 !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL x0_we got %b%b want 00", write_enable_3, busy); end
    vecs++; if (grant_count_1 !== 4'd1) begin errs++; $display("FAIL x0_cnt got %0d want 1", grant_count_1); end
    vecs++; if (read_data_1 !== 32'h55) begin errs++; $display("FAIL x0_read got %h want 55", read_data_1); end
    @(negedge clk); wb_valid_1 = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    wb_valid_0 = 1; wb_addr_0 = 9; wb_data_0 = 32'h99;
    rd_addr_1 = 9; rf_read_data_1 = 32'h1;
    @(posedge clk);
    @(negedge clk); wb_valid_0 = 0; rst = 1; #1;
    vecs++; if (write_enable_3 !== 1'b0 || read_data_1 !== 32'h1) begin errs++; $display("FAIL mid_during got we=%b d=%h want 0/1", write_enable_3, read_data_1); end
    @(posedge clk); #1;
    vecs++; if (write_enable_3 !== 1'b0 || addr_3 !== 5'd0) begin errs++; $display("FAIL mid_after got we=%b a=%0d want 0/0", write_enable_3, addr_3); end
    @(negedge clk); rst = 0; wb_valid_0 = 1; wb_valid_1 = 1; wb_addr_1 = 2; #1;
    vecs++; if ({wb_ready_0, wb_ready_1} !== 2'b10) begin errs++; $display("FAIL mid_rrptr got %b want 10", {wb_ready_0, wb_ready_1}); end
    wb_valid_0 = 0; wb_valid_1 = 0;
    @(posedge clk); #1;
    vecs++; if (write_enable_3 !== 1'b0) begin errs++; $display("FAIL mid_nowrite got %b want 0", write_enable_3); end
  endtask

  task automatic test_saturate();
    do_reset();
    wb_valid_0 = 1; wb_addr_0 = 1;
    for (int i = 0; i < 17; i++) begin
      wb_data_0 = i;
      @(posedge clk); @(negedge clk);
    end
    wb_valid_0 = 0;
    vecs++; if (grant_count_0 !== 4'hF || grant_count_1 !== 4'h0) begin errs++; $display("FAIL sat_cnt got %0d/%0d want 15/0", grant_count_0, grant_count_1); end
  endtask

  initial begin
    idle_inputs(); rst = 1;
    test_reset();
    test_single();
    test_contention();
    test_same_addr_fwd();
    test_x0();
    test_reset_mid();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
